// File: rtl/emmc_card_cmd_responder_pkg.sv
// Shared JEDEC eMMC CMD-line constants and types for the card and host engines.
package jedec_p;

  localparam int unsigned CMD_FRAME_LEN = 48;
  localparam logic [6:0]  CRC7_POLY     = 7'h09;
  localparam logic [5:0]  R3_IDX        = 6'h3F;
  localparam logic [6:0]  R3_CRC        = 7'h7F;

  // Encoding 3 is not named and is handled as RSP_NONE.
  typedef enum logic [1:0] {
    RSP_NONE = 2'd0,
    RSP_R1   = 2'd1,
    RSP_R3   = 2'd2
  } rsp_kind_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RX,
    ST_CHECK,
    ST_WAIT_RSP,
    ST_TX
  } card_state_e;

  // One serial CRC7 step (x^7 + x^3 + 1), MSB-first data.
  function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic din);
    logic fb;
    fb = din ^ crc[6];
    return {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
  endfunction

endpackage

// File: rtl/emmc_card_cmd_responder_crc7.sv
// Serial CRC7 generator for the eMMC CMD line.
module emmc_crc7
  import jedec_p::*;
(
  input  logic       clk_i,
  input  logic       arst_i,
  input  logic       clr_i,
  input  logic       en_i,
  input  logic       bit_i,
  output logic [6:0] crc_o
);

  // clr together with en restarts the CRC from zero with this bit as the first one.
  always_ff @(posedge clk_i) begin
    if (arst_i) begin
      crc_o <= '0;
    end else if (en_i) begin
      crc_o <= crc7_step(clr_i ? 7'h00 : crc_o, bit_i);
    end else if (clr_i) begin
      crc_o <= '0;
    end
  end

endmodule

// File: rtl/emmc_card_cmd_responder.sv
// Card-side eMMC CMD line: receives 48-bit host commands, answers with R1/R3.
module emmc_card_cmd_responder
  import jedec_p::*;
#(
  parameter int unsigned NCR     = 2,
  parameter int unsigned NCR_MAX = 64
) (
  input  logic        clk_i,
  input  logic        arst_i,
  input  logic        cmd_i,
  output logic        cmd_o,
  output logic        cmd_oe_o,
  output logic        cmd_valid_o,
  output logic [5:0]  cmd_idx_o,
  output logic [31:0] cmd_arg_o,
  output logic        cmd_crc_err_o,
  input  logic        rsp_valid_i,
  output logic        rsp_ready_o,
  input  logic [1:0]  rsp_kind_i,
  input  logic [5:0]  rsp_idx_i,
  input  logic [31:0] rsp_arg_i,
  output logic        busy_o
);

  if (NCR < 2) begin : g_bad_ncr
    $error("emmc_card_cmd_responder: NCR must be at least 2");
  end
  if (NCR_MAX <= NCR) begin : g_bad_ncr_max
    $error("emmc_card_cmd_responder: NCR_MAX must exceed NCR");
  end

  localparam int unsigned WCW      = $clog2(NCR_MAX + 2);
  localparam logic [5:0]  LAST_BIT = 6'(CMD_FRAME_LEN - 1);
  localparam logic [5:0]  CRC_BITS = 6'(CMD_FRAME_LEN - 8);

  card_state_e     state_q, state_d;
  logic [5:0]      bit_cnt_q;
  logic [46:0]     rx_sr_q;
  logic            frame_ok_q, crc_ok_q;
  logic [WCW-1:0]  wait_cnt_q;
  logic            rsp_held_q;
  logic            tx_r3_q;
  logic [39:0]     tx_sr_q;
  logic [5:0]      tx_cnt_q;
  logic [6:0]      rx_crc, tx_crc;

  logic [47:0]     rx_frame;
  logic            rx_last, rx_frame_ok, rx_crc_ok;
  logic            cmd_good, rsp_hs, rsp_none, ncr_reached, timeout;

  assign rx_frame    = {rx_sr_q, cmd_i};
  assign rx_last     = (state_q == ST_RX) && (bit_cnt_q == LAST_BIT);
  assign rx_frame_ok = ~rx_frame[47] & rx_frame[46] & rx_frame[0];
  assign rx_crc_ok   = (rx_frame[7:1] == rx_crc);
  assign cmd_good    = (state_q == ST_CHECK) && frame_ok_q && crc_ok_q;
  assign rsp_hs      = rsp_valid_i & rsp_ready_o;
  assign rsp_none    = !((rsp_kind_i == RSP_R1) || (rsp_kind_i == RSP_R3));
  // wait_cnt_q counts cycles since the end bit, so TX may start next cycle once it reaches NCR-1.
  assign ncr_reached = (32'(wait_cnt_q) + 32'd1) >= NCR;
  assign timeout     = (32'(wait_cnt_q) == NCR_MAX);

  emmc_crc7 u_rx_crc (
    .clk_i  (clk_i),
    .arst_i (arst_i),
    .clr_i  (state_q == ST_IDLE),
    .en_i   (((state_q == ST_IDLE) && !cmd_i) ||
             ((state_q == ST_RX) && (bit_cnt_q < CRC_BITS))),
    .bit_i  (cmd_i),
    .crc_o  (rx_crc)
  );

  emmc_crc7 u_tx_crc (
    .clk_i  (clk_i),
    .arst_i (arst_i),
    .clr_i  (rsp_hs),
    .en_i   ((state_q == ST_TX) && (tx_cnt_q < CRC_BITS)),
    .bit_i  (tx_sr_q[39]),
    .crc_o  (tx_crc)
  );

  // State register.
  always_ff @(posedge clk_i) begin
    if (arst_i) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; a handshake in the timeout cycle still wins.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (!cmd_i) state_d = ST_RX;
      ST_RX:   if (rx_last) state_d = ST_CHECK;
      ST_CHECK, ST_WAIT_RSP: begin
        if ((state_q == ST_CHECK) && !(frame_ok_q && crc_ok_q)) begin
          state_d = ST_IDLE;
        end else if (rsp_held_q) begin
          if (ncr_reached) state_d = ST_TX;
        end else if (rsp_hs) begin
          if (rsp_none)         state_d = ST_IDLE;
          else if (ncr_reached) state_d = ST_TX;
          else                  state_d = ST_WAIT_RSP;
        end else if (timeout) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WAIT_RSP;
        end
      end
      ST_TX:   if (tx_cnt_q == LAST_BIT) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from state; ready is offered already in CHECK so a controller
  // answering alongside cmd_valid_o meets the minimum NCR latency.
  always_comb begin
    cmd_o         = 1'b1;
    cmd_oe_o      = 1'b0;
    cmd_valid_o   = (state_q == ST_CHECK) && frame_ok_q;
    cmd_crc_err_o = (state_q == ST_CHECK) && frame_ok_q && !crc_ok_q;
    rsp_ready_o   = (cmd_good || (state_q == ST_WAIT_RSP)) && !rsp_held_q;
    busy_o        = (state_q != ST_IDLE);
    if (state_q == ST_TX) begin
      cmd_oe_o = 1'b1;
      if (tx_cnt_q < CRC_BITS)      cmd_o = tx_sr_q[39];
      else if (tx_cnt_q < LAST_BIT) cmd_o = tx_r3_q ? 1'b1 : tx_crc[3'd6 - tx_cnt_q[2:0]];
      else                          cmd_o = 1'b1;
    end
  end

  // Receive shifter, command capture, response capture and transmit shifter.
  always_ff @(posedge clk_i) begin
    if (arst_i) begin
      bit_cnt_q  <= '0;
      rx_sr_q    <= '0;
      frame_ok_q <= 1'b0;
      crc_ok_q   <= 1'b0;
      wait_cnt_q <= '0;
      rsp_held_q <= 1'b0;
      tx_r3_q    <= 1'b0;
      tx_sr_q    <= '0;
      tx_cnt_q   <= '0;
      cmd_idx_o  <= '0;
      cmd_arg_o  <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          bit_cnt_q  <= 6'd1;
          rsp_held_q <= 1'b0;
          rx_sr_q    <= {rx_sr_q[45:0], cmd_i};
        end
        ST_RX: begin
          bit_cnt_q <= bit_cnt_q + 6'd1;
          rx_sr_q   <= {rx_sr_q[45:0], cmd_i};
          if (rx_last) begin
            frame_ok_q <= rx_frame_ok;
            crc_ok_q   <= rx_crc_ok;
            wait_cnt_q <= WCW'(1);
            if (rx_frame_ok) begin
              cmd_idx_o <= rx_frame[45:40];
              cmd_arg_o <= rx_frame[39:8];
            end
          end
        end
        ST_CHECK, ST_WAIT_RSP: begin
          wait_cnt_q <= wait_cnt_q + WCW'(1);
          if (rsp_hs) begin
            rsp_held_q <= 1'b1;
            tx_r3_q    <= (rsp_kind_i == RSP_R3);
            tx_sr_q    <= {2'b00, (rsp_kind_i == RSP_R3) ? R3_IDX : rsp_idx_i, rsp_arg_i};
            tx_cnt_q   <= '0;
          end
        end
        ST_TX: begin
          tx_cnt_q <= tx_cnt_q + 6'd1;
          tx_sr_q  <= {tx_sr_q[38:0], 1'b0};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_emmc_card_cmd_responder.sv
// Directed bench for the card-side eMMC CMD responder.
module tb_emmc_card_cmd_responder;

  localparam int unsigned NCR     = 2;
  localparam int unsigned NCR_MAX = 64;

  logic        clk_i = 1'b0;
  logic        arst_i, cmd_i, cmd_o, cmd_oe_o, cmd_valid_o, cmd_crc_err_o;
  logic [5:0]  cmd_idx_o;
  logic [31:0] cmd_arg_o;
  logic        rsp_valid_i, rsp_ready_o, busy_o;
  logic [1:0]  rsp_kind_i;
  logic [5:0]  rsp_idx_i;
  logic [31:0] rsp_arg_i;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  emmc_card_cmd_responder #(.NCR(NCR), .NCR_MAX(NCR_MAX)) dut (
    .clk_i         (clk_i),
    .arst_i        (arst_i),
    .cmd_i         (cmd_i),
    .cmd_o         (cmd_o),
    .cmd_oe_o      (cmd_oe_o),
    .cmd_valid_o   (cmd_valid_o),
    .cmd_idx_o     (cmd_idx_o),
    .cmd_arg_o     (cmd_arg_o),
    .cmd_crc_err_o (cmd_crc_err_o),
    .rsp_valid_i   (rsp_valid_i),
    .rsp_ready_o   (rsp_ready_o),
    .rsp_kind_i    (rsp_kind_i),
    .rsp_idx_i     (rsp_idx_i),
    .rsp_arg_i     (rsp_arg_i),
    .busy_o        (busy_o)
  );

  typedef struct {
    logic [47:0] frame;
    logic [1:0]  kind;
    logic [5:0]  ridx;
    logic [31:0] rarg;
    logic        ev;
    logic        eerr;
    logic [5:0]  eidx;
    logic [31:0] earg;
    logic        etx;
    logic [47:0] etx_frame;
  } vec_t;

  vec_t vecs[7];

  function automatic logic [6:0] crc7_model(input logic [39:0] d);
    logic [6:0] c;
    logic fb;
    c = '0;
    for (int i = 39; i >= 0; i--) begin
      fb = d[i] ^ c[6];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return c;
  endfunction

  function automatic logic [47:0] make_frame(input logic [39:0] head);
    return {head, crc7_model(head), 1'b1};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Caller is positioned at a falling edge; returns at the falling edge of cycle E.
  task automatic send_frame(input logic [47:0] f);
    cmd_i = f[47];
    for (int i = 46; i >= 0; i--) begin
      @(negedge clk_i);
      cmd_i = f[i];
    end
  endtask

  task automatic collect_tx(output logic [47:0] f, output int n);
    f = '0;
    n = 0;
    for (int i = 0; i < 48; i++) begin
      if (i != 0) @(negedge clk_i);
      f = {f[46:0], cmd_o};
      if (cmd_oe_o) n++;
    end
    @(negedge clk_i);
  endtask

  task automatic check_tx_tail(input string tag, input logic [47:0] f, input int n,
                               input logic [47:0] exp);
    check($sformatf("%s_txframe", tag), 64'(f), 64'(exp));
    check($sformatf("%s_oe_cycles", tag), 64'(n), 64'd48);
    check($sformatf("%s_oe_after", tag), 64'(cmd_oe_o), 64'd0);
    check($sformatf("%s_cmd_after", tag), 64'(cmd_o), 64'd1);
    check($sformatf("%s_busy_after", tag), 64'(busy_o), 64'd0);
  endtask

  task automatic run_vector(input vec_t v, input string tag);
    logic [47:0] f;
    int n;
    send_frame(v.frame);
    @(negedge clk_i);                      // cycle E+1
    cmd_i = 1'b1;
    check($sformatf("%s_valid", tag), 64'(cmd_valid_o), 64'(v.ev));
    check($sformatf("%s_crc_err", tag), 64'(cmd_crc_err_o), 64'(v.eerr));
    check($sformatf("%s_idx", tag), 64'(cmd_idx_o), 64'(v.eidx));
    check($sformatf("%s_arg", tag), 64'(cmd_arg_o), 64'(v.earg));
    check($sformatf("%s_ready", tag), 64'(rsp_ready_o), 64'(v.ev && !v.eerr));
    check($sformatf("%s_oe_e1", tag), 64'(cmd_oe_o), 64'd0);
    if (v.ev && !v.eerr) begin
      rsp_valid_i = 1'b1;
      rsp_kind_i  = v.kind;
      rsp_idx_i   = v.ridx;
      rsp_arg_i   = v.rarg;
    end
    @(negedge clk_i);                      // cycle E+2 = E+NCR
    rsp_valid_i = 1'b0;
    if (v.etx) begin
      check($sformatf("%s_start_oe", tag), 64'(cmd_oe_o), 64'd1);
      check($sformatf("%s_start_bit", tag), 64'(cmd_o), 64'd0);
      collect_tx(f, n);
      check_tx_tail(tag, f, n, v.etx_frame);
    end else begin
      check($sformatf("%s_busy_e2", tag), 64'(busy_o), 64'd0);
      check($sformatf("%s_oe_e2", tag), 64'(cmd_oe_o), 64'd0);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check($sformatf("%s_cmd_o", tag), 64'(cmd_o), 64'd1);
    check($sformatf("%s_oe", tag), 64'(cmd_oe_o), 64'd0);
    check($sformatf("%s_valid", tag), 64'(cmd_valid_o), 64'd0);
    check($sformatf("%s_crc_err", tag), 64'(cmd_crc_err_o), 64'd0);
    check($sformatf("%s_ready", tag), 64'(rsp_ready_o), 64'd0);
    check($sformatf("%s_busy", tag), 64'(busy_o), 64'd0);
    check($sformatf("%s_idx", tag), 64'(cmd_idx_o), 64'd0);
    check($sformatf("%s_arg", tag), 64'(cmd_arg_o), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [47:0] f;
    int n;
    int rdy;

    vecs[0] = '{48'h400000000095, 2'd0, 6'd0, 32'd0, 1'b1, 1'b0, 6'd0, 32'd0, 1'b0, 48'd0};
    vecs[1] = '{48'h48000001AA87, 2'd1, 6'd8, 32'h000001AA, 1'b1, 1'b0, 6'd8, 32'h000001AA,
                1'b1, make_frame({2'b00, 6'd8, 32'h000001AA})};
    vecs[2] = '{make_frame({8'h41, 32'h40FF8080}), 2'd2, 6'd5, 32'h80FF8080, 1'b1, 1'b0,
                6'd1, 32'h40FF8080, 1'b1, 48'h3F80FF8080FF};
    vecs[3] = '{48'h48000001AE87, 2'd0, 6'd0, 32'd0, 1'b1, 1'b1, 6'd8, 32'h000001AE, 1'b0, 48'd0};
    vecs[4] = '{48'h08000001AA87, 2'd0, 6'd0, 32'd0, 1'b0, 1'b0, 6'd8, 32'h000001AE, 1'b0, 48'd0};
    vecs[5] = '{48'h48000001AA86, 2'd0, 6'd0, 32'd0, 1'b0, 1'b0, 6'd8, 32'h000001AE, 1'b0, 48'd0};
    vecs[6] = '{48'h400000000095, 2'd1, 6'd0, 32'h00000900, 1'b1, 1'b0, 6'd0, 32'd0,
                1'b1, make_frame({2'b00, 6'd0, 32'h00000900})};

    arst_i      = 1'b1;
    cmd_i       = 1'b1;
    rsp_valid_i = 1'b0;
    rsp_kind_i  = 2'd0;
    rsp_idx_i   = '0;
    rsp_arg_i   = '0;
    repeat (3) @(negedge clk_i);
    check_reset_outputs("reset");
    arst_i = 1'b0;
    @(negedge clk_i);

    for (int i = 0; i < 7; i++) begin
      run_vector(vecs[i], $sformatf("vec%0d", i));
      @(negedge clk_i);
    end

    // No response offered: ready stays up through E+NCR_MAX, then the command is dropped.
    send_frame(48'h400000000095);
    @(negedge clk_i);
    check("to_valid", 64'(cmd_valid_o), 64'd1);
    rdy = 0;
    for (int k = 1; k <= int'(NCR_MAX); k++) begin
      if (k != 1) @(negedge clk_i);
      if (rsp_ready_o) rdy++;
    end
    check("to_ready_cycles", 64'(rdy), 64'(NCR_MAX));
    @(negedge clk_i);
    check("to_ready_drop", 64'(rsp_ready_o), 64'd0);
    check("to_busy_drop", 64'(busy_o), 64'd0);
    run_vector(vecs[1], "after_to");

    // Handshake landing on the timeout cycle is still served.
    send_frame(48'h400000000095);
    @(negedge clk_i);
    for (int k = 2; k <= int'(NCR_MAX); k++) @(negedge clk_i);
    check("late_ready", 64'(rsp_ready_o), 64'd1);
    rsp_valid_i = 1'b1;
    rsp_kind_i  = 2'd2;
    rsp_arg_i   = 32'h00FF8000;
    @(negedge clk_i);
    rsp_valid_i = 1'b0;
    check("late_start_oe", 64'(cmd_oe_o), 64'd1);
    collect_tx(f, n);
    check_tx_tail("late", f, n, 48'h3F00FF8000FF);

    // Reset while response bit 20 is on the line.
    send_frame(48'h48000001AA87);
    @(negedge clk_i);
    rsp_valid_i = 1'b1;
    rsp_kind_i  = 2'd1;
    rsp_idx_i   = 6'd8;
    rsp_arg_i   = 32'h000001AA;
    @(negedge clk_i);
    rsp_valid_i = 1'b0;
    repeat (20) @(negedge clk_i);
    check("rst_mid_oe_before", 64'(cmd_oe_o), 64'd1);
    arst_i = 1'b1;
    @(negedge clk_i);
    check_reset_outputs("rst_mid");
    arst_i = 1'b0;
    run_vector(vecs[0], "after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
